// File: rtl/riscv_next_tournament_predictor.sv
// Tournament direction predictor: bimodal + gshare sub-predictors with a per-PC chooser.
// Registered 1-cycle lookup, exact resolve-time update, speculative history repair.
module riscv_next_tournament_predictor #(
  parameter int ADDR_WIDTH      = 64,
  parameter int ADDR_SHIFT      = 1,
  parameter int HIST_WIDTH      = 10,
  parameter int BIM_INDEX_WIDTH = 10,
  parameter int COUNTER_WIDTH   = 2,
  parameter int CHOOSER_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic                  i_stall,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_read_addr,
  input  logic                  i_shift_history,
  input  logic                  i_flush_history,
  output logic                  o_read_valid,
  output logic                  o_read_jump,
  output logic                  o_read_bim,
  output logic                  o_read_gsh,
  output logic [HIST_WIDTH-1:0] o_read_hist,
  input  logic                  i_write_enable,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic                  i_write_jump,
  input  logic                  i_write_mispredict,
  input  logic                  i_write_bim,
  input  logic                  i_write_gsh,
  input  logic [HIST_WIDTH-1:0] i_write_hist
);

  localparam int SWEEP_WIDTH = (HIST_WIDTH > BIM_INDEX_WIDTH) ? HIST_WIDTH : BIM_INDEX_WIDTH;
  localparam int BIM_DEPTH   = 1 << BIM_INDEX_WIDTH;
  localparam int GSH_DEPTH   = 1 << HIST_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CTR_WEAK = COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);
  localparam logic [CHOOSER_WIDTH-1:0] CHO_WEAK = CHOOSER_WIDTH'((1 << (CHOOSER_WIDTH - 1)) - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  function automatic logic [COUNTER_WIDTH-1:0] ctr_step(input logic [COUNTER_WIDTH-1:0] ctr,
                                                        input logic up);
    if (up) return (ctr == '1) ? ctr : ctr + COUNTER_WIDTH'(1);
    else    return (ctr == '0) ? ctr : ctr - COUNTER_WIDTH'(1);
  endfunction

  function automatic logic [CHOOSER_WIDTH-1:0] cho_step(input logic [CHOOSER_WIDTH-1:0] ctr,
                                                        input logic up);
    if (up) return (ctr == '1) ? ctr : ctr + CHOOSER_WIDTH'(1);
    else    return (ctr == '0) ? ctr : ctr - CHOOSER_WIDTH'(1);
  endfunction

  state_t                 state_q, state_d;
  logic [SWEEP_WIDTH-1:0] sweep_q, sweep_d;
  logic                   running;
  logic [HIST_WIDTH-1:0]  spec_hist_q, commit_hist_q, commit_hist_next;

  // NOTE: reset is synchronous, so nreset is sampled only inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (enable && state_q == ST_INIT) begin
      sweep_d = sweep_q + SWEEP_WIDTH'(1);
      if (sweep_q == '1) state_d = ST_RUN;
    end
  end

  assign running = (state_q == ST_RUN);
  assign o_ready = running;

  logic [ADDR_WIDTH-1:0]      read_pc, write_pc;
  logic [BIM_INDEX_WIDTH-1:0] read_bim_idx, write_bim_idx;
  logic [HIST_WIDTH-1:0]      read_gsh_idx, write_gsh_idx;
  logic                       unused_addr_bits;

  assign read_pc       = i_read_addr >> ADDR_SHIFT;
  assign write_pc      = i_write_addr >> ADDR_SHIFT;
  assign read_bim_idx  = read_pc[BIM_INDEX_WIDTH-1:0];
  assign write_bim_idx = write_pc[BIM_INDEX_WIDTH-1:0];
  assign read_gsh_idx  = read_pc[HIST_WIDTH-1:0] ^ spec_hist_q;
  assign write_gsh_idx = write_pc[HIST_WIDTH-1:0] ^ i_write_hist;
  assign unused_addr_bits = ^{i_read_addr, i_write_addr, read_pc, write_pc};

  logic [COUNTER_WIDTH-1:0] bim_mem [BIM_DEPTH];
  logic [COUNTER_WIDTH-1:0] gsh_mem [GSH_DEPTH];
  logic [CHOOSER_WIDTH-1:0] cho_mem [BIM_DEPTH];

  logic                       bim_we, gsh_we, cho_we;
  logic [BIM_INDEX_WIDTH-1:0] bim_widx;
  logic [HIST_WIDTH-1:0]      gsh_widx;
  logic [COUNTER_WIDTH-1:0]   bim_wdata, gsh_wdata;
  logic [CHOOSER_WIDTH-1:0]   cho_wdata;

  // One write port per table: the INIT sweep owns it until RUN, then resolved branches do.
  always_comb begin
    bim_we    = 1'b0;
    gsh_we    = 1'b0;
    cho_we    = 1'b0;
    bim_widx  = write_bim_idx;
    gsh_widx  = write_gsh_idx;
    bim_wdata = ctr_step(bim_mem[write_bim_idx], i_write_jump);
    gsh_wdata = ctr_step(gsh_mem[write_gsh_idx], i_write_jump);
    cho_wdata = cho_step(cho_mem[write_bim_idx], i_write_gsh == i_write_jump);
    if (enable) begin
      if (!running) begin
        bim_we    = 1'b1;
        gsh_we    = 1'b1;
        cho_we    = 1'b1;
        bim_widx  = sweep_q[BIM_INDEX_WIDTH-1:0];
        gsh_widx  = sweep_q[HIST_WIDTH-1:0];
        bim_wdata = CTR_WEAK;
        gsh_wdata = CTR_WEAK;
        cho_wdata = CHO_WEAK;
      end else if (i_write_enable) begin
        bim_we = 1'b1;
        gsh_we = 1'b1;
        cho_we = (i_write_bim != i_write_gsh);
      end
    end
  end

  // NOTE: table storage has no reset term; the INIT sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (bim_we) bim_mem[bim_widx] <= bim_wdata;
    if (gsh_we) gsh_mem[gsh_widx] <= gsh_wdata;
    if (cho_we) cho_mem[bim_widx] <= cho_wdata;
  end

  logic look_bim, look_gsh, look_cho;

  assign look_bim = bim_mem[read_bim_idx][COUNTER_WIDTH-1];
  assign look_gsh = gsh_mem[read_gsh_idx][COUNTER_WIDTH-1];
  assign look_cho = cho_mem[read_bim_idx][CHOOSER_WIDTH-1];

  // Reads see the pre-update table contents when a write hits the same index.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      o_read_valid <= 1'b0;
      o_read_jump  <= 1'b0;
      o_read_bim   <= 1'b0;
      o_read_gsh   <= 1'b0;
      o_read_hist  <= '0;
    end else if (enable) begin
      if (!running) begin
        o_read_valid <= 1'b0;
      end else if (!i_stall) begin
        o_read_valid <= 1'b1;
        o_read_jump  <= look_cho ? look_gsh : look_bim;
        o_read_bim   <= look_bim;
        o_read_gsh   <= look_gsh;
        o_read_hist  <= spec_hist_q;
      end
    end
  end

  assign commit_hist_next = i_write_enable ? {commit_hist_q[HIST_WIDTH-2:0], i_write_jump}
                                           : commit_hist_q;

  // Mispredict repair outranks flush, which outranks the speculative shift.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      spec_hist_q   <= '0;
      commit_hist_q <= '0;
    end else if (enable && running) begin
      commit_hist_q <= commit_hist_next;
      if (!i_stall) begin
        if (i_write_enable && i_write_mispredict)
          spec_hist_q <= {i_write_hist[HIST_WIDTH-2:0], i_write_jump};
        else if (i_flush_history)
          spec_hist_q <= commit_hist_next;
        else if (i_shift_history)
          spec_hist_q <= {spec_hist_q[HIST_WIDTH-2:0], o_read_jump};
      end
    end
  end

endmodule

// File: tb/tb_riscv_next_tournament_predictor.sv
// Directed scoreboard bench for the tournament predictor with 4-bit history and index.
module tb_riscv_next_tournament_predictor;

  localparam int AW = 64;
  localparam int HW = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic          enable;
  logic          i_stall;
  logic          o_ready;
  logic [AW-1:0] i_read_addr;
  logic          i_shift_history;
  logic          i_flush_history;
  logic          o_read_valid, o_read_jump, o_read_bim, o_read_gsh;
  logic [HW-1:0] o_read_hist;
  logic          i_write_enable;
  logic [AW-1:0] i_write_addr;
  logic          i_write_jump, i_write_mispredict, i_write_bim, i_write_gsh;
  logic [HW-1:0] i_write_hist;

  riscv_next_tournament_predictor #(
    .ADDR_WIDTH(AW), .ADDR_SHIFT(1), .HIST_WIDTH(HW), .BIM_INDEX_WIDTH(4),
    .COUNTER_WIDTH(2), .CHOOSER_WIDTH(2)
  ) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .i_stall(i_stall), .o_ready(o_ready),
    .i_read_addr(i_read_addr), .i_shift_history(i_shift_history),
    .i_flush_history(i_flush_history), .o_read_valid(o_read_valid),
    .o_read_jump(o_read_jump), .o_read_bim(o_read_bim), .o_read_gsh(o_read_gsh),
    .o_read_hist(o_read_hist), .i_write_enable(i_write_enable),
    .i_write_addr(i_write_addr), .i_write_jump(i_write_jump),
    .i_write_mispredict(i_write_mispredict), .i_write_bim(i_write_bim),
    .i_write_gsh(i_write_gsh), .i_write_hist(i_write_hist)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          valid;
    logic          jump;
    logic          bim;
    logic          gsh;
    logic [HW-1:0] hist;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Push the expected registered result, clock once, then pop and compare.
  task automatic expect_cycle(input string tag, input logic v, input logic j, input logic b,
                              input logic g, input logic [HW-1:0] h);
    exp_t e;
    e.tag = tag; e.valid = v; e.jump = j; e.bim = b; e.gsh = g; e.hist = h;
    sb.push_back(e);
    step();
    e = sb.pop_front();
    check({e.tag, ".valid"}, o_read_valid, e.valid);
    check({e.tag, ".jump"},  o_read_jump,  e.jump);
    check({e.tag, ".bim"},   o_read_bim,   e.bim);
    check({e.tag, ".gsh"},   o_read_gsh,   e.gsh);
    check({e.tag, ".hist"},  o_read_hist,  e.hist);
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic j, input logic m,
                             input logic b, input logic g, input logic [HW-1:0] h);
    i_write_enable = 1'b1; i_write_addr = a; i_write_jump = j;
    i_write_mispredict = m; i_write_bim = b; i_write_gsh = g; i_write_hist = h;
  endtask

  task automatic clear_write();
    i_write_enable = 1'b0;
    i_write_mispredict = 1'b0;
  endtask

  task automatic write_only(input logic [AW-1:0] a, input logic j, input logic b,
                            input logic g, input logic [HW-1:0] h);
    drive_write(a, j, 1'b0, b, g, h);
    step();
    clear_write();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!o_ready && n < 200) begin
      n++;
      step();
    end
    check(tag, n, 16);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    nreset = 1'b0; enable = 1'b1; i_stall = 1'b0; i_read_addr = '0;
    i_shift_history = 1'b0; i_flush_history = 1'b0;
    i_write_enable = 1'b0; i_write_addr = '0; i_write_jump = 1'b0;
    i_write_mispredict = 1'b0; i_write_bim = 1'b0; i_write_gsh = 1'b0; i_write_hist = '0;

    // T1: reset state, 16-cycle INIT sweep, first lookup
    step(); step();
    check("rst.ready", o_ready, 0);
    check("rst.valid", o_read_valid, 0);
    check("rst.jump",  o_read_jump, 0);
    check("rst.bim",   o_read_bim, 0);
    check("rst.gsh",   o_read_gsh, 0);
    check("rst.hist",  o_read_hist, 0);
    nreset = 1'b1;
    i_read_addr = 64'h40;
    wait_ready("t1.init_cycles");
    check("t1.init_valid", o_read_valid, 0);
    expect_cycle("t1.first", 1, 0, 0, 0, 4'h0);

    // T2: bimodal (and gshare idx 0) trained taken; chooser stays at bimodal
    write_only(64'h40, 1, 0, 0, 4'h0);
    write_only(64'h40, 1, 0, 0, 4'h0);
    expect_cycle("t2.lookup", 1, 1, 1, 1, 4'h0);
    write_only(64'h42, 1, 0, 0, 4'h0);
    write_only(64'h42, 1, 0, 0, 4'h0);

    // T3: chooser pushed toward gshare; bimodal drained to strong not-taken
    for (int i = 0; i < 3; i++) write_only(64'h40, 0, 1, 0, 4'h5);
    expect_cycle("t3.follow_gsh", 1, 1, 0, 1, 4'h0);

    // T4: speculative shifts, then mispredict repair beating a shift
    i_read_addr = 64'h42;
    expect_cycle("t4.pre", 1, 1, 1, 1, 4'h0);
    i_shift_history = 1'b1;
    expect_cycle("t4.sh1", 1, 1, 1, 1, 4'h0);
    expect_cycle("t4.sh2", 1, 1, 1, 1, 4'h1);
    expect_cycle("t4.sh3", 1, 1, 1, 0, 4'h3);
    i_shift_history = 1'b0;
    expect_cycle("t4.hist0111", 1, 1, 1, 0, 4'h7);
    drive_write(64'h4c, 0, 1, 0, 0, 4'h2);
    i_shift_history = 1'b1;
    expect_cycle("t4.mis_cycle", 1, 1, 1, 0, 4'h7);
    clear_write();
    i_shift_history = 1'b0;
    expect_cycle("t4.repaired", 1, 1, 1, 0, 4'h4);

    // Flush takes the committed history including the same-cycle write
    drive_write(64'h50, 1, 0, 0, 0, 4'h0);
    i_flush_history = 1'b1;
    expect_cycle("flush.cycle", 1, 1, 1, 0, 4'h4);
    clear_write();
    i_flush_history = 1'b0;
    expect_cycle("flush.result", 1, 1, 1, 1, 4'h1);

    // T5: stall holds outputs and spec history; writes still land
    i_stall = 1'b1;
    i_shift_history = 1'b1;
    i_read_addr = 64'h40;
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 3) drive_write(64'h44, 1, 0, 0, 0, 4'h0);
      expect_cycle($sformatf("t5.hold%0d", i), 1, 1, 1, 1, 4'h1);
      clear_write();
    end
    i_stall = 1'b0;
    i_shift_history = 1'b0;
    i_read_addr = 64'h44;
    expect_cycle("t5.after", 1, 1, 1, 0, 4'h1);

    // enable=0 freezes outputs, writes and history
    enable = 1'b0;
    i_read_addr = 64'h40;
    i_shift_history = 1'b1;
    drive_write(64'h44, 0, 1, 0, 0, 4'h0);
    expect_cycle("en.hold0", 1, 1, 1, 0, 4'h1);
    expect_cycle("en.hold1", 1, 1, 1, 0, 4'h1);
    enable = 1'b1;
    clear_write();
    i_shift_history = 1'b0;
    i_read_addr = 64'h44;
    expect_cycle("en.after", 1, 1, 1, 0, 4'h1);

    // T6: reset mid-sweep at index 7 restarts the full sweep
    nreset = 1'b0;
    step(); step();
    check("t6.rst_ready", o_ready, 0);
    check("t6.rst_valid", o_read_valid, 0);
    nreset = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("t6.mid_ready", o_ready, 0);
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    wait_ready("t6.init_cycles");
    i_read_addr = 64'h50;
    expect_cycle("t6.lookup", 1, 0, 0, 0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
